// File: rtl/song_reader_pkg.sv
// Shared types for the song reader: note/duration widths, FSM state
// encoding and the ROM entry layout {note[11:6], duration[5:0]}.
package song_reader_pkg;

    localparam int NOTE_W  = 6;
    localparam int DUR_W   = 6;
    localparam int ENTRY_W = NOTE_W + DUR_W;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_ROM,
        LOAD,
        WAIT_DONE,
        END
    } state_e;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } rom_entry_t;

    function automatic rom_entry_t mk_entry(input int unsigned n,
                                            input int unsigned d);
        rom_entry_t e;
        e.note = n[NOTE_W-1:0];
        e.dur  = d[DUR_W-1:0];
        return e;
    endfunction

endpackage

// File: rtl/song_rom.sv
// Synchronous song ROM, one-cycle read latency, 12-bit {note, duration}.
// Ports: clk, addr_i = {song, index}, data_o = registered entry.
// The table below is the song_rom.hex image written out as logic so the
// ROM elaborates without an external file. Duration 0 marks end of song.
module song_rom
    import song_reader_pkg::*;
#(
    parameter int IDX_W  = 5,
    parameter int SONG_W = 2
) (
    input  logic                    clk,
    input  logic [SONG_W+IDX_W-1:0] addr_i,
    output rom_entry_t              data_o
);

    function automatic rom_entry_t lookup(input logic [SONG_W+IDX_W-1:0] a);
        int unsigned s;
        int unsigned k;
        rom_entry_t  e;
        s = 32'(a[SONG_W+IDX_W-1:IDX_W]);
        k = 32'(a[IDX_W-1:0]);
        case (s)
            0: begin
                if (k == 0)      e = mk_entry(1, 5);
                else if (k == 1) e = mk_entry(12, 3);
                else             e = mk_entry(k + 2, (k % 4) + 1);
            end
            1: begin
                if (k == 0)      e = mk_entry(7, 2);
                else if (k == 1) e = mk_entry(9, 4);
                else if (k == 2) e = mk_entry(0, 0);
                else             e = mk_entry(k, 1);
            end
            2: begin
                // entry 3 is a rest (note 0), entry 10 ends the song
                if (k == 0)       e = mk_entry(20, 6);
                else if (k == 3)  e = mk_entry(0, 4);
                else if (k == 10) e = mk_entry(0, 0);
                else              e = mk_entry(k + 20, 2);
            end
            default: e = mk_entry(63 - k, (k % 8) + 1);
        endcase
        return e;
    endfunction

    always_ff @(posedge clk) begin
        data_o <= lookup(addr_i);
    end

endmodule

// File: rtl/song_reader.sv
// Song reader: walks a song in ROM and hands each note/duration to a
// note player, one note per note_done handshake.
// Ports: clk, reset (async, active low), play, song, note_done in;
//        note, duration, new_note (pulse), song_done (pulse) out.
// Build option: SONG_READER_LOOP_EN makes a song wrap to its first note
// instead of finishing (no song_done, END unreachable).
module song_reader
    import song_reader_pkg::*;
#(
    parameter int IDX_W  = 5,
    parameter int SONG_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic [SONG_W-1:0] song,
    input  logic              note_done,
    output logic [NOTE_W-1:0] note,
    output logic [DUR_W-1:0]  duration,
    output logic              new_note,
    output logic              song_done
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SONG_W-1:0] song_q, song_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              done_q, done_d;
    logic              finish;
    rom_entry_t        rom_q;

    song_rom #(
        .IDX_W  (IDX_W),
        .SONG_W (SONG_W)
    ) u_rom (
        .clk    (clk),
        .addr_i ({song_q, idx_q}),
        .data_o (rom_q)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        song_d   = song_q;
        note_d   = note_q;
        dur_d    = dur_q;
        new_note = 1'b0;
        finish   = 1'b0;
        // a new song selection overrides whatever the reader was doing
        if (state_q != IDLE && song != song_q) begin
            song_d  = song;
            idx_d   = '0;
            state_d = play ? FETCH : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (play) begin
                        song_d  = song;
                        idx_d   = '0;
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (play) state_d = WAIT_ROM;
                end
                WAIT_ROM: begin
                    if (play) begin
                        if (rom_q.dur == '0) begin
                            finish = 1'b1;
                        end else begin
                            note_d  = rom_q.note;
                            dur_d   = rom_q.dur;
                            state_d = LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (play) begin
                        new_note = 1'b1;
                        state_d  = WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // advances even when paused; the stall happens at FETCH
                    if (note_done) begin
                        if (idx_q == '1) begin
                            finish = 1'b1;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = FETCH;
                        end
                    end
                end
                END: begin
                end
                default: state_d = IDLE;
            endcase
        end
        if (finish) begin
`ifdef SONG_READER_LOOP_EN
            idx_d   = '0;
            state_d = FETCH;
`else
            state_d = END;
`endif
        end
        done_d = (state_d == END) && (state_q != END);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            song_q  <= '0;
            note_q  <= '0;
            dur_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            song_q  <= song_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            done_q  <= done_d;
        end
    end

    assign note      = note_q;
    assign duration  = dur_q;
    assign song_done = done_q;

endmodule

// File: tb/tb_song_reader.sv
// Scoreboard bench for song_reader: a behavioural model predicts every
// new_note / song_done event; a negedge monitor compares DUT events.
module tb_song_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       play;
    logic [1:0] song;
    logic       note_done;
    logic [5:0] note;
    logic [5:0] duration;
    logic       new_note;
    logic       song_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    song_reader dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .song      (song),
        .note_done (note_done),
        .note      (note),
        .duration  (duration),
        .new_note  (new_note),
        .song_done (song_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         is_done;
        logic [5:0] note;
        logic [5:0] dur;
    } exp_t;

    exp_t q[$];

    // Reference song contents as {note, duration}
    function automatic logic [11:0] ref_entry(input int s, input int k);
        int n;
        int d;
        case (s)
            0: begin
                n = (k == 0) ? 1 : (k == 1) ? 12 : k + 2;
                d = (k == 0) ? 5 : (k == 1) ? 3 : 1 + (k % 4);
            end
            1: begin
                n = (k == 0) ? 7 : (k == 1) ? 9 : (k == 2) ? 0 : k;
                d = (k == 0) ? 2 : (k == 1) ? 4 : (k == 2) ? 0 : 1;
            end
            2: begin
                n = (k == 0) ? 20 : (k == 3 || k == 10) ? 0 : k + 20;
                d = (k == 0) ? 6 : (k == 3) ? 4 : (k == 10) ? 0 : 2;
            end
            default: begin
                n = 63 - k;
                d = 1 + (k % 8);
            end
        endcase
        return {n[5:0], d[5:0]};
    endfunction

    // Model: a note needs three playing cycles (address, read, hand-off);
    // it then sounds until note_done.
    typedef enum {M_IDLE, M_FETCH, M_HOLD, M_END} mmode_e;
    mmode_e m_mode = M_IDLE;
    int     m_song = 0;
    int     m_idx  = 0;
    int     m_prog = 0;

    task automatic song_over();
`ifdef SONG_READER_LOOP_EN
        m_idx  = 0;
        m_prog = 0;
        m_mode = M_FETCH;
`else
        exp_t e;
        m_mode    = M_END;
        e.cyc     = cyc + 1;
        e.is_done = 1'b1;
        e.note    = '0;
        e.dur     = '0;
        q.push_back(e);
`endif
    endtask

    task automatic model_step(input bit p, input int s, input bit nd);
        logic [11:0] ent;
        exp_t        e;
        if (m_mode != M_IDLE && s != m_song) begin
            m_song = s;
            m_idx  = 0;
            m_prog = 0;
            m_mode = p ? M_FETCH : M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: if (p) begin
                    m_song = s;
                    m_idx  = 0;
                    m_prog = 0;
                    m_mode = M_FETCH;
                end
                M_FETCH: if (p) begin
                    ent = ref_entry(m_song, m_idx);
                    if (m_prog == 0) begin
                        m_prog = 1;
                    end else if (m_prog == 1) begin
                        if (ent[5:0] == 6'd0) song_over();
                        else m_prog = 2;
                    end else begin
                        e.cyc     = cyc;
                        e.is_done = 1'b0;
                        e.note    = ent[11:6];
                        e.dur     = ent[5:0];
                        q.push_back(e);
                        m_mode = M_HOLD;
                    end
                end
                M_HOLD: if (nd) begin
                    if (m_idx == 31) begin
                        song_over();
                    end else begin
                        m_idx  = m_idx + 1;
                        m_prog = 0;
                        m_mode = M_FETCH;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit p, input int s, input bit nd);
        @(posedge clk);
        #1;
        play      = p;
        song      = s[1:0];
        note_done = nd;
        model_step(p, s, nd);
    endtask

    task automatic run(input int n, input bit p, input int s);
        for (int i = 0; i < n; i++) step(p, s, 1'b0);
    endtask

    task automatic hit_reset();
        @(posedge clk);
        #3;
        reset     = 1'b0;
        play      = 1'b0;
        note_done = 1'b0;
        #1;
        chk("rst_note", int'(note), 0);
        chk("rst_duration", int'(duration), 0);
        chk("rst_new_note", int'(new_note), 0);
        chk("rst_song_done", int'(song_done), 0);
        q.delete();
        m_mode = M_IDLE;
        m_song = 0;
        m_idx  = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_step(1'b0, int'(song), 1'b0);
    endtask

    // Monitor: every DUT event must match the head of the expectation queue
    always @(negedge clk) begin : monitor
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missed_event: cycle %0d done=%0d note=%0d dur=%0d not seen",
                     q[0].cyc, q[0].is_done, q[0].note, q[0].dur);
            void'(q.pop_front());
        end
        if (new_note && song_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL overlap: new_note and song_done both high at cycle %0d", cyc);
        end
        if (new_note || song_done) begin
            n_checks++;
            if (q.size() == 0 || q[0].cyc != cyc) begin
                n_fail++;
                $display("FAIL unexpected_event: cycle %0d new_note=%0d song_done=%0d",
                         cyc, new_note, song_done);
            end else begin
                e = q.pop_front();
                if (e.is_done != song_done ||
                    (!e.is_done && (note != e.note || duration != e.dur))) begin
                    n_fail++;
                    $display("FAIL event_data: cycle %0d got done=%0d note=%0d dur=%0d expected done=%0d note=%0d dur=%0d",
                             cyc, song_done, note, duration, e.is_done, e.note, e.dur);
                end
            end
        end
    end

    initial begin
        int cur;
        reset     = 1'b0;
        play      = 1'b0;
        song      = 2'd0;
        note_done = 1'b0;
        #2;
        chk("init_note", int'(note), 0);
        chk("init_duration", int'(duration), 0);
        chk("init_new_note", int'(new_note), 0);
        chk("init_song_done", int'(song_done), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_step(1'b0, 0, 1'b0);

        // first two notes of song 0
        run(6, 1'b1, 0);
        step(1'b1, 0, 1'b1);
        run(5, 1'b1, 0);
        // pause across a note_done, then resume
        step(1'b0, 0, 1'b1);
        run(4, 1'b0, 0);
        run(4, 1'b1, 0);
        // switch to song 2 while a note is sounding
        run(6, 1'b1, 2);
        // song 1 hits its end marker after two notes
        run(6, 1'b1, 1);
        step(1'b1, 1, 1'b1);
        run(5, 1'b1, 1);
        step(1'b1, 1, 1'b1);
        run(6, 1'b1, 1);
        step(1'b1, 1, 1'b1);
        run(3, 1'b1, 1);
        // reset while a note of song 0 is sounding, then restart
        run(6, 1'b1, 0);
        hit_reset();
        run(6, 1'b1, 0);
        // play all 32 entries of song 3
        for (int i = 0; i < 33; i++) begin
            run(4, 1'b1, 3);
            step(1'b1, 3, 1'b1);
        end
        run(4, 1'b1, 3);

        // randomized traffic
        cur = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) hit_reset();
            if ($urandom_range(0, 39) == 0) cur = $urandom_range(0, 3);
            step($urandom_range(0, 9) != 0, cur, $urandom_range(0, 3) == 0);
        end
        run(6, 1'b0, cur);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        while (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL leftover_event: cycle %0d done=%0d note=%0d never seen",
                     q[0].cyc, q[0].is_done, q[0].note);
            void'(q.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/song_reader.md
SONG_READER -- requirements
Module: song_reader

Interface
REQ-001 Parameter: IDX_W, default 5, note-index width; 2**IDX_W notes per song.
REQ-002 Parameter: SONG_W, default 2, song-select width; 2**SONG_W songs.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 Port: play  input  1  level; 1 = advance through song, 0 = pause.
REQ-006 Port: song  input  SONG_W  selected song.
REQ-007 Port: note_done  input  1  one-cycle pulse from note player: current note finished (done_with_note).
REQ-008 Port: note  output  6  note code to load (load target note_to_load); 0 = rest.
REQ-009 Port: duration  output  6  note length in beats (duration_to_load).
REQ-010 Port: new_note  output  1  one-cycle pulse; note/duration valid (load_new_note).
REQ-011 Port: song_done  output  1  one-cycle pulse at end of song.

Function
REQ-012 FSM states SHALL be IDLE, FETCH, WAIT_ROM, LOAD, WAIT_DONE, END.
REQ-013 IDLE -> FETCH when play=1; song latched, index=0.
REQ-014 FETCH drives ROM address {song_latched, index}; next state WAIT_ROM.
REQ-015 ROM read latency SHALL be exactly one cycle; WAIT_ROM registers ROM data into note/duration, next state LOAD.
REQ-016 LOAD asserts new_note for exactly one cycle, next state WAIT_DONE; new_note asserted 2 cycles after FETCH entry.
REQ-017 note/duration SHALL hold stable from LOAD until next WAIT_ROM update.
REQ-018 WAIT_DONE on note_done=1: if index = 2**IDX_W-1 -> END, else index+1 -> FETCH; next new_note exactly 3 cycles after note_done.
REQ-019 ROM entry with duration=0 is end marker: WAIT_ROM -> END, no new_note issued.
REQ-020 Entering END asserts song_done for exactly one cycle; END holds until song input differs from song_latched.
REQ-021 Song change (song != song_latched) in any non-IDLE state SHALL, next cycle, latch new song, index=0, go to FETCH if play=1 else IDLE; takes priority over note_done.
REQ-022 play=0 in FETCH/WAIT_ROM/LOAD SHALL stall state (no new_note); WAIT_DONE still accepts note_done (advance completes, stall at FETCH).
REQ-023 note_done outside WAIT_DONE SHALL be ignored.
REQ-024 new_note and song_done SHALL never be asserted in the same cycle.

Reset
REQ-025 reset=0 SHALL immediately force IDLE, index=0, song_latched=0, note=0, duration=0, new_note=0, song_done=0.
REQ-026 Reset mid-note SHALL discard progress; after release, restart at note 0 on play=1.

Configuration
REQ-027 Macro SONG_READER_LOOP_EN: defined -> last-entry completion or end marker wraps index to 0 and goes to FETCH, no song_done, END unreachable; undefined -> behaviour per REQ-018..020.

Structure
REQ-028 Shared package SHALL hold NOTE_W=6, DUR_W=6, state enum, ROM entry layout {note[11:6], duration[5:0]}.
REQ-029 Sub-module song_rom: synchronous ROM, address SONG_W+IDX_W bits, 12-bit data, 1-cycle latency, contents from song_rom.hex.

Verification
REQ-030 Reset release, play=1, song=0, entry0={1,5} -> new_note at cycle 2 after FETCH entry, note=1, duration=5.
REQ-031 note_done pulse in WAIT_DONE, entry1={12,3} -> new_note 3 cycles later, note=12, duration=3.
REQ-032 Song1 entry2 duration=0 -> after note 1 done, song_done one cycle, no third new_note; with SONG_READER_LOOP_EN, new_note of entry0 instead.
REQ-033 play=0 during WAIT_DONE, note_done pulse -> no new_note until play=1, then new_note 2 cycles later.
REQ-034 song 0->2 during WAIT_DONE -> next new_note carries song2 entry0, song_done stays 0.
REQ-035 reset=0 asserted mid-WAIT_DONE -> outputs zero same cycle without clk edge; restart yields song0 entry0.
